// File: rtl/axis_sensor_frame_mux.sv
// axis_sensor_frame_mux: round-robin arbiter over N fixed-width AXI-stream
// sensor channels. Each granted sample is emitted as a byte frame made of a
// header {seq[3:0], channel_id[3:0]} followed by DATA_WIDTH/8 payload bytes,
// with m_tlast on the final payload byte.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. s_tready is only ever raised in IDLE, for the selected
// channel only, and m_tvalid never depends on m_tready. While m_tvalid is high
// and m_tready is low, m_tdata/m_tlast stay stable.
module axis_sensor_frame_mux #(
    parameter int N_CHANNELS = 2,
    parameter int DATA_WIDTH = 48,
    parameter int BIG_ENDIAN = 0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [N_CHANNELS*DATA_WIDTH-1:0] s_tdata,
    input  logic [N_CHANNELS-1:0]            s_tvalid,
    output logic [N_CHANNELS-1:0]            s_tready,
    output logic [7:0]                       m_tdata,
    output logic                             m_tvalid,
    input  logic                             m_tready,
    output logic                             m_tlast,
    output logic [1:0]                       dbg_state_o
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int CH_W  = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BYTES - 1);
    localparam logic [CH_W-1:0]  LAST_CHAN = CH_W'(N_CHANNELS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CH_W-1:0]         grant_q;   // doubles as last_grant between frames
    logic [IDX_W-1:0]        idx_q;
    logic [DATA_WIDTH-1:0]   sample_q;
    logic [3:0]              seq_q [N_CHANNELS];

    logic                    found;
    logic [CH_W-1:0]         sel;
    logic [CH_W-1:0]         cand;
    logic [3:0]              chan_id;
    logic [IDX_W-1:0]        byte_sel;
    logic [7:0]              payload_byte;

    assign dbg_state_o = state_q;

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = (grant_q == LAST_CHAN) ? '0 : grant_q + 1'b1;
        for (int k = 0; k < N_CHANNELS; k++) begin
            if (!found && s_tvalid[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
            cand = (cand == LAST_CHAN) ? '0 : cand + 1'b1;
        end
    end

    // Input ready: only the selected channel, and only while idle.
    always_comb begin
        s_tready = '0;
        if (state_q == IDLE && found) begin
            s_tready[sel] = 1'b1;
        end
    end

    // Header ID and payload byte selection for the current frame.
    always_comb begin
        chan_id             = '0;
        chan_id[CH_W-1:0]   = grant_q;
        byte_sel            = (BIG_ENDIAN != 0) ? (LAST_IDX - idx_q) : idx_q;
        payload_byte        = sample_q[byte_sel*8 +: 8];
    end

    // Next-state and output decode.
    always_comb begin
        state_d  = state_q;
        m_tvalid = 1'b0;
        m_tdata  = 8'h00;
        m_tlast  = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = HEADER;
                end
            end
            HEADER: begin
                m_tvalid = 1'b1;
                m_tdata  = {seq_q[grant_q], chan_id};
                if (m_tready) begin
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                m_tvalid = 1'b1;
                m_tdata  = payload_byte;
                m_tlast  = (idx_q == LAST_IDX);
                if (m_tready && m_tlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, captured sample, grant, byte index and per-channel sequence.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= LAST_CHAN;
            idx_q    <= '0;
            sample_q <= '0;
            for (int i = 0; i < N_CHANNELS; i++) begin
                seq_q[i] <= 4'h0;
            end
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && found) begin
                sample_q <= s_tdata[sel*DATA_WIDTH +: DATA_WIDTH];
                grant_q  <= sel;
            end
            if (state_q == HEADER && m_tready) begin
                seq_q[grant_q] <= seq_q[grant_q] + 4'h1;
                idx_q          <= '0;
            end
            if (state_q == PAYLOAD && m_tready && !m_tlast) begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis_sensor_frame_mux.sv
// Testbench for axis_sensor_frame_mux: a 3-channel little-endian instance and
// a 1-channel big-endian instance. Expected bytes are queued when stimulus is
// issued; negedge monitors pop and compare each accepted output byte.
module tb_axis_sensor_frame_mux;

  logic         clk;
  logic         reset;
  logic [143:0] s_tdata;
  logic [2:0]   s_tvalid;
  logic [2:0]   s_tready;
  logic [7:0]   m_tdata;
  logic         m_tvalid;
  logic         m_tready;
  logic         m_tlast;
  logic [1:0]   dbg_state;

  logic [47:0]  be_s_tdata;
  logic [0:0]   be_s_tvalid;
  logic [0:0]   be_s_tready;
  logic [7:0]   be_m_tdata;
  logic         be_m_tvalid;
  logic         be_m_tlast;
  logic [1:0]   be_dbg_state;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cnt = 0;
  logic bp = 1'b0;

  logic [8:0] exp_q[$];
  logic [8:0] be_q[$];
  logic [3:0] seq_m [3];

  logic       stall_prev = 1'b0;
  logic [8:0] stall_val = '0;

  axis_sensor_frame_mux #(.N_CHANNELS(3), .DATA_WIDTH(48), .BIG_ENDIAN(0)) dut (
    .clk(clk), .reset(reset), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tready(s_tready), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tlast(m_tlast), .dbg_state_o(dbg_state)
  );

  axis_sensor_frame_mux #(.N_CHANNELS(1), .DATA_WIDTH(48), .BIG_ENDIAN(1)) dut_be (
    .clk(clk), .reset(reset), .s_tdata(be_s_tdata), .s_tvalid(be_s_tvalid),
    .s_tready(be_s_tready), .m_tdata(be_m_tdata), .m_tvalid(be_m_tvalid),
    .m_tready(m_tready), .m_tlast(be_m_tlast), .dbg_state_o(be_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  // Downstream ready: always high, or ~30% duty when bp is set.
  always @(posedge clk) begin
    #1;
    m_tready = bp ? ($urandom_range(0, 9) < 3) : 1'b1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    s_tvalid = '0;
    be_s_tvalid = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) seq_m[i] = 4'h0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_frame(input int ch, input logic [47:0] d, input int npay);
    exp_q.push_back({1'b0, seq_m[ch], 4'(ch)});
    seq_m[ch] = seq_m[ch] + 4'h1;
    for (int k = 0; k < npay; k++) begin
      exp_q.push_back({(k == 5), d[k*8 +: 8]});
    end
  endtask

  task automatic send(input int ch, input logic [47:0] d);
    int n;
    logic [1:0] c;
    c = ch[1:0];
    s_tdata[ch*48 +: 48] = d;
    s_tvalid[c] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_tready[c] && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("send_timeout", 64'(n), 64'd0);
    @(posedge clk);
    #1;
    s_tvalid[c] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || be_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_exp_q", 64'(exp_q.size()), 64'd0);
    check("drain_be_q", 64'(be_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic round_robin();
    int g;
    int n;
    int grants[6];
    push_frame(0, 48'h1010_2020_3030, 6);
    push_frame(1, 48'h4141_5151_6161, 6);
    push_frame(2, 48'h7272_8282_9292, 6);
    push_frame(0, 48'h1010_2020_3030, 6);
    push_frame(1, 48'h4141_5151_6161, 6);
    push_frame(2, 48'h7272_8282_9292, 6);
    s_tdata = {48'h7272_8282_9292, 48'h4141_5151_6161, 48'h1010_2020_3030};
    s_tvalid = 3'b111;
    g = 0;
    n = 0;
    while (g < 6 && n < 2000) begin
      @(negedge clk);
      n++;
      if (|s_tready) begin
        grants[g] = s_tready[1] ? 1 : (s_tready[2] ? 2 : 0);
        g++;
        if (g == 6) begin
          @(posedge clk);
          #1;
          s_tvalid = '0;
        end
      end
    end
    s_tvalid = '0;
    check("rr_grant_count", 64'(g), 64'd6);
    for (int i = 0; i < g; i++) check("rr_grant_order", 64'(grants[i]), 64'(i % 3));
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    if (!reset) begin
      check("s_tready_onehot0", 64'($onehot0(s_tready)), 64'd1);
      if (stall_prev && m_tvalid) check("stall_stable", {55'd0, m_tlast, m_tdata}, {55'd0, stall_val});
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_byte: got 0x%0h last=%0b, expected none", m_tdata, m_tlast);
        end else begin
          check("out_byte", {55'd0, m_tlast, m_tdata}, {55'd0, exp_q.pop_front()});
          acc_cnt++;
        end
      end
      stall_prev = m_tvalid && !m_tready;
      stall_val = {m_tlast, m_tdata};
    end else begin
      stall_prev = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!reset && be_m_tvalid && m_tready) begin
      if (be_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL be_unexpected_byte: got 0x%0h last=%0b, expected none", be_m_tdata, be_m_tlast);
      end else begin
        check("be_out_byte", {55'd0, be_m_tlast, be_m_tdata}, {55'd0, be_q.pop_front()});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int c1;
    int c2;
    int n;
    int base;
    reset = 1'b1;
    s_tdata = '0;
    s_tvalid = '0;
    be_s_tdata = '0;
    be_s_tvalid = '0;
    m_tready = 1'b1;
    for (int i = 0; i < 3; i++) seq_m[i] = 4'h0;

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_m_tlast", 64'(m_tlast), 64'd0);
    check("rst_m_tdata", 64'(m_tdata), 64'd0);
    check("rst_s_tready", 64'(s_tready), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    check("rst_be_m_tvalid", 64'(be_m_tvalid), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single sample on channel 0, twice; latency and frame period.
    push_frame(0, 48'h0605_0403_0201, 6);
    push_frame(0, 48'h0605_0403_0201, 6);
    send(0, 48'h0605_0403_0201);
    c1 = cyc;
    @(negedge clk);
    check("hdr_latency_valid", 64'(m_tvalid), 64'd1);
    send(0, 48'h0605_0403_0201);
    c2 = cyc;
    check("frame_period", 64'(c2 - c1), 64'd8);
    drain();

    // Round-robin with all channels valid.
    do_reset();
    round_robin();
    drain();

    // Back-pressure: same traffic, downstream ready at ~30%.
    do_reset();
    bp = 1'b1;
    push_frame(0, 48'h0605_0403_0201, 6);
    push_frame(0, 48'h0605_0403_0201, 6);
    send(0, 48'h0605_0403_0201);
    send(0, 48'h0605_0403_0201);
    drain();
    do_reset();
    round_robin();
    drain();
    bp = 1'b0;

    // Sequence wrap: 17 frames on channel 1.
    do_reset();
    for (int f = 0; f < 17; f++) begin
      push_frame(1, {8'hC0, 8'(f), 32'h1234_5678}, 6);
      send(1, {8'hC0, 8'(f), 32'h1234_5678});
    end
    drain();

    // Big-endian instance, two frames.
    do_reset();
    for (int f = 0; f < 2; f++) begin
      be_q.push_back({1'b0, 4'(f), 4'h0});
      be_q.push_back(9'h0AA);
      be_q.push_back(9'h0BB);
      be_q.push_back(9'h0CC);
      be_q.push_back(9'h0DD);
      be_q.push_back(9'h0EE);
      be_q.push_back(9'h1FF);
      be_s_tdata = 48'hAABB_CCDD_EEFF;
      be_s_tvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!be_s_tready[0] && n < 500) begin
        @(negedge clk);
        n++;
      end
      if (n >= 500) check("be_send_timeout", 64'(n), 64'd0);
      @(posedge clk);
      #1;
      be_s_tvalid = 1'b0;
    end
    drain();

    // Reset after the third payload byte of a channel-1 frame.
    do_reset();
    push_frame(1, 48'h0F0E_0D0C_0B0A, 3);
    base = acc_cnt;
    send(1, 48'h0F0E_0D0C_0B0A);
    n = 0;
    while (acc_cnt < base + 4 && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("midrst_bytes_before", 64'(acc_cnt - base), 64'd4);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("midrst_m_tlast", 64'(m_tlast), 64'd0);
    check("midrst_state", 64'(dbg_state), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) seq_m[i] = 4'h0;
    check("midrst_queue_empty", 64'(exp_q.size()), 64'd0);
    push_frame(0, 48'h5555_6666_7777, 6);
    push_frame(1, 48'h8888_9999_AAAA, 6);
    fork
      send(0, 48'h5555_6666_7777);
      send(1, 48'h8888_9999_AAAA);
    join
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
